// File: rtl/prog_checkpoint_monitor.sv
// rtl/prog_checkpoint_monitor.sv - checkpoint/watchdog run supervisor for the single-cycle processor
//
// Purpose: follows the processor PC against up to NUM_CKPT checkpoint addresses.
// For each checkpoint reached it waits SETTLE_CYC cycles, compares dmemout with the
// expected value and counts the result. A global watchdog aborts runaway programs.
//
// Ports:
//   i_clk, i_reset        clock, asynchronous active-high reset
//   i_start               one-cycle arm pulse (ignored while busy)
//   i_ckpt_count          number of active checkpoints (clamped to NUM_CKPT)
//   i_ckpt_pc/i_ckpt_exp  flat checkpoint addresses / expected values
//   i_currentpc/i_dmemout processor PC and data-memory read output
//   o_busy, o_done        RUN|SETTLE, DONE|TIMEOUT
//   o_all_pass            every active checkpoint passed, no timeout
//   o_pass_count          checkpoints passed so far
//   o_cur_index           checkpoint currently awaited
//   o_fail_valid          one-cycle pulse after a failing compare
//   o_fail_index/actual   index and dmemout of the most recent failure
//   o_watchdog_expired    high in TIMEOUT
module prog_checkpoint_monitor #(
    parameter int DATA_W     = 64,
    parameter int PC_W       = 64,
    parameter int NUM_CKPT   = 4,
    parameter int SETTLE_CYC = 1,
    parameter int WD_W       = 16,
    parameter logic [WD_W-1:0] WD_LIMIT = 'hFF,
    localparam int CW        = $clog2(NUM_CKPT + 1)
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_start,
    input  logic [CW-1:0]            i_ckpt_count,
    input  logic [NUM_CKPT*PC_W-1:0] i_ckpt_pc,
    input  logic [NUM_CKPT*DATA_W-1:0] i_ckpt_exp,
    input  logic [PC_W-1:0]          i_currentpc,
    input  logic [DATA_W-1:0]        i_dmemout,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_all_pass,
    output logic [CW-1:0]            o_pass_count,
    output logic [CW-1:0]            o_cur_index,
    output logic                     o_fail_valid,
    output logic [CW-1:0]            o_fail_index,
    output logic [DATA_W-1:0]        o_fail_actual,
    output logic                     o_watchdog_expired
);

    localparam int SW = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_SETTLE, S_DONE, S_TIMEOUT} state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic [NUM_CKPT*PC_W-1:0]   r_ckpt_pc;
    logic [NUM_CKPT*DATA_W-1:0] r_ckpt_exp;
    logic [CW-1:0]              r_count;
    logic [CW-1:0]              r_pass;
    logic [CW-1:0]              r_idx;
    logic [WD_W-1:0]            r_wd;
    logic [SW-1:0]              r_settle;
    logic                       r_fail_valid;
    logic [CW-1:0]              r_fail_idx;
    logic [DATA_W-1:0]          r_fail_act;

    logic                       w_busy;
    logic                       w_start_ok;
    logic [CW-1:0]              w_count_clamp;
    logic [PC_W-1:0]            w_cur_pc;
    logic [DATA_W-1:0]          w_cur_exp;
    logic                       w_wd_hit;
    logic                       w_detect;
    logic                       w_check;
    logic                       w_last;
    logic                       w_match;

    assign w_busy        = (r_state == S_RUN) || (r_state == S_SETTLE);
    assign w_start_ok    = i_start && !w_busy;
    assign w_count_clamp = (i_ckpt_count > CW'(NUM_CKPT)) ? CW'(NUM_CKPT) : i_ckpt_count;

    // Select the awaited checkpoint; r_idx can equal NUM_CKPT after the last
    // check, so an explicit compare avoids an out-of-range part-select.
    always_comb begin
        w_cur_pc  = '0;
        w_cur_exp = '0;
        for (int i = 0; i < NUM_CKPT; i++) begin
            if (r_idx == CW'(i)) begin
                w_cur_pc  = r_ckpt_pc[i*PC_W +: PC_W];
                w_cur_exp = r_ckpt_exp[i*DATA_W +: DATA_W];
            end
        end
    end

    // Expiry is flagged on the edge that would bring the count to WD_LIMIT.
    assign w_wd_hit = w_busy && ((r_wd + WD_W'(1)) == WD_LIMIT);
    assign w_detect = (r_state == S_RUN) && (i_currentpc >= w_cur_pc);
    assign w_check  = (r_state == S_SETTLE) && (r_settle == SW'(1));
    assign w_last   = ((r_idx + CW'(1)) == r_count);
    assign w_match  = (i_dmemout == w_cur_exp);

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    // Next-state logic; a final check wins over a coincident watchdog expiry.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_TIMEOUT: begin
                if (w_start_ok) w_state_next = (w_count_clamp == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (w_wd_hit)      w_state_next = S_TIMEOUT;
                else if (w_detect) w_state_next = S_SETTLE;
            end
            S_SETTLE: begin
                if (w_check && w_last) w_state_next = S_DONE;
                else if (w_wd_hit)     w_state_next = S_TIMEOUT;
                else if (w_check)      w_state_next = S_RUN;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ckpt_pc    <= '0;
            r_ckpt_exp   <= '0;
            r_count      <= '0;
            r_pass       <= '0;
            r_idx        <= '0;
            r_wd         <= '0;
            r_settle     <= '0;
            r_fail_valid <= 1'b0;
            r_fail_idx   <= '0;
            r_fail_act   <= '0;
        end else begin
            r_fail_valid <= 1'b0;
            if (w_start_ok) begin
                r_ckpt_pc  <= i_ckpt_pc;
                r_ckpt_exp <= i_ckpt_exp;
                r_count    <= w_count_clamp;
                r_pass     <= '0;
                r_idx      <= '0;
                r_wd       <= '0;
                r_fail_idx <= '0;
                r_fail_act <= '0;
            end else begin
                // Counting only while busy makes the watchdog hold in TIMEOUT.
                if (w_busy && (r_wd != WD_LIMIT)) r_wd <= r_wd + WD_W'(1);
                if (w_detect)                     r_settle <= SW'(SETTLE_CYC);
                else if (r_state == S_SETTLE)     r_settle <= r_settle - SW'(1);
                if (w_check) begin
                    if (w_match) begin
                        r_pass <= r_pass + CW'(1);
                    end else begin
                        r_fail_valid <= 1'b1;
                        r_fail_idx   <= r_idx;
                        r_fail_act   <= i_dmemout;
                    end
                    r_idx <= r_idx + CW'(1);
                end
            end
        end
    end

    // Outputs
    always_comb begin
        o_busy             = w_busy;
        o_done             = (r_state == S_DONE) || (r_state == S_TIMEOUT);
        o_watchdog_expired = (r_state == S_TIMEOUT);
        o_all_pass         = (r_state == S_DONE) && (r_pass == r_count);
        o_pass_count       = r_pass;
        o_cur_index        = r_idx;
        o_fail_valid       = r_fail_valid;
        o_fail_index       = r_fail_idx;
        o_fail_actual      = r_fail_act;
    end

endmodule

// File: doc/prog_checkpoint_monitor.md
# prog_checkpoint_monitor

Synthesizable run-supervisor for the single-cycle processor. It tracks `currentpc` against a list of up to NUM_CKPT checkpoint addresses. Each time a checkpoint is reached it waits a settle interval, compares `dmemout` against that checkpoint's expected value, and tallies the result. A global watchdog aborts runaway programs. It sits beside `singlecycle` on the same clock, in simulation and in FPGA self-test builds.

## Interface
- DATA_W, 64, width of `dmemout` and expected values
- PC_W, 64, width of `currentpc` and checkpoint addresses
- NUM_CKPT, 4, maximum number of checkpoints (≥1)
- SETTLE_CYC, 1, cycles between checkpoint detection and the `dmemout` sample (≥1)
- WD_W, 16, watchdog counter width
- WD_LIMIT, 16'hFF, watchdog expiry count
- CLK  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; returns block to IDLE
- start  in  1  one-cycle arm pulse; ignored while busy
- ckpt_count  in  $clog2(NUM_CKPT+1)  number of active checkpoints; values above NUM_CKPT clamp to NUM_CKPT
- ckpt_pc  in  NUM_CKPT*PC_W  flat checkpoint addresses; entry i at bits [i*PC_W +: PC_W]
- ckpt_exp  in  NUM_CKPT*DATA_W  flat expected values, same packing
- currentpc  in  PC_W  processor PC
- dmemout  in  DATA_W  processor data-memory read output
- busy  out  1  high in RUN or SETTLE
- done  out  1  high in DONE or TIMEOUT; held until next start
- all_pass  out  1  valid when done; 1 iff every active checkpoint passed and no timeout
- pass_count  out  $clog2(NUM_CKPT+1)  checkpoints passed so far
- cur_index  out  $clog2(NUM_CKPT+1)  index of the checkpoint being awaited
- fail_valid  out  1  one-cycle pulse on a failing compare
- fail_index  out  $clog2(NUM_CKPT+1)  index of the most recent failure
- fail_actual  out  DATA_W  `dmemout` captured at the most recent failure
- watchdog_expired  out  1  high in TIMEOUT

## Operation
- States: IDLE, RUN, SETTLE, DONE, TIMEOUT.
- Reset: state IDLE. All outputs are 0, including counters, index, fail fields and the watchdog.
- IDLE/DONE/TIMEOUT + start:
  - Latch ckpt_pc, ckpt_exp and the clamped ckpt_count.
  - Clear pass_count, cur_index, watchdog, fail_index and fail_actual.
  - Go to RUN, or to DONE with all_pass=1 if the clamped count is 0.
- RUN: each edge where currentpc ≥ latched ckpt_pc[cur_index] (unsigned), load settle counter = SETTLE_CYC and go to SETTLE.
- SETTLE:
  - Decrement the counter each edge.
  - On the edge where the counter is 1, compare dmemout against ckpt_exp[cur_index].
  - Equal: pass_count+1.
  - Unequal: fail_valid=1 for the following cycle, and capture fail_index=cur_index and fail_actual=dmemout.
  - cur_index+1. If cur_index was the last active checkpoint, go to DONE; otherwise go to RUN.
- DONE: all_pass = (pass_count == latched count).
- Watchdog:
  - Increments each edge while busy.
  - On the edge where it reaches WD_LIMIT, go to TIMEOUT with all_pass=0 and watchdog_expired=1.
  - It does not reset between checkpoints.
- Simultaneous events:
  - Final-check edge coinciding with watchdog expiry: the check is recorded and the block goes to DONE (timeout ignored).
  - Non-final check coinciding with expiry: the check is recorded and the block goes to TIMEOUT.
- start while busy: ignored. Latched checkpoint data is unaffected.
- reset mid-run: immediate return to IDLE with all outputs cleared. A pending fail_valid pulse is dropped.
- Arithmetic: pass_count and cur_index never exceed NUM_CKPT. The watchdog saturates in TIMEOUT.

## Timing
- start sampled at edge E0 → busy=1 after E0.
- Checkpoint condition seen at edge Ed → `dmemout` compared at edge Ed+SETTLE_CYC. Results (pass_count, fail_*, state) are visible after that edge.
- done rises in the same cycle that the last compare result becomes visible.
- fail_valid is high for exactly one cycle. fail_index/fail_actual are held until the next failure, start or reset.
- A checkpoint whose address is already ≤ currentpc on RUN entry is detected on the first RUN edge.

## Test plan
- ckpt_count=2, ckpts (0x34,0xF),(0x54,0x123456789ABCDEF0); processor runs the standard program → pass_count=2, done=1, all_pass=1, fail_valid never asserted.
- Same setup with ckpt_exp[1]=0x0 → fail_valid pulse with fail_index=1 and fail_actual=0x123456789ABCDEF0; final pass_count=1, all_pass=0.
- ckpt0 address 0x1000, never reached, WD_LIMIT=0xFF → TIMEOUT exactly 0xFF edges after start, watchdog_expired=1, all_pass=0, cur_index=0.
- SETTLE_CYC=3 with a stub driving dmemout=0xF only from the third cycle after PC≥0x34 → pass. The same stub with SETTLE_CYC=2 → fail.
- ckpt_count=0 → done=1, all_pass=1 one cycle after start. ckpt_count=7 with NUM_CKPT=4 → clamps to 4 checkpoints.
- Assert reset while in SETTLE → all outputs 0 immediately. A re-issued start runs the 2-checkpoint program to all_pass=1. A start pulse while busy is ignored (pass_count unaffected).
